// File: rtl/preg_free_list_pkg.sv
// Shared core parameters for the physical-register rename machinery
// (free list and rename table).
package preg_free_list_pkg;

    localparam int unsigned CORE_PREG_WIDTH = 6;
    localparam int unsigned CORE_NUM_PREG   = 64;
    localparam int unsigned CORE_NUM_AREG   = 32;
    localparam int unsigned CORE_FL_DEPTH   = CORE_NUM_PREG - CORE_NUM_AREG;
    localparam int unsigned CORE_FL_IDX_W   = $clog2(CORE_FL_DEPTH);
    // Free-list pointers carry one extra wrap bit above the index.
    localparam int unsigned CORE_FL_PTR_W   = CORE_FL_IDX_W + 1;

    typedef logic [CORE_PREG_WIDTH-1:0] preg_tag_t;
    typedef logic [CORE_FL_PTR_W-1:0]   fl_ptr_t;

endpackage

// File: rtl/preg_free_list.sv
// Physical-register free list: circular buffer with speculative head,
// committed head and tail pointers; flush rewinds speculative allocations.
module preg_free_list
    import preg_free_list_pkg::*;
#(
    parameter int unsigned PREG_WIDTH = CORE_PREG_WIDTH,
    parameter int unsigned NUM_PREG   = CORE_NUM_PREG,
    parameter int unsigned NUM_AREG   = CORE_NUM_AREG,
    parameter int unsigned FL_DEPTH   = NUM_PREG - NUM_AREG
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        alloc_req,
    output logic                        alloc_valid,
    output logic [PREG_WIDTH-1:0]       alloc_tag,
    input  logic                        retire_valid,
    input  logic [PREG_WIDTH-1:0]       retire_old_tag,
    input  logic                        flush,
    output logic [$clog2(FL_DEPTH):0]   free_count,
    output logic                        err
);

    localparam int unsigned IDX_W = $clog2(FL_DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;

    logic [PREG_WIDTH-1:0] mem_q [FL_DEPTH];
    logic [PTR_W-1:0]      spec_head_q, spec_head_d;
    logic [PTR_W-1:0]      com_head_q,  com_head_d;
    logic [PTR_W-1:0]      tail_q,      tail_d;
    logic                  err_q,       err_d;

    logic                  alloc_fire;
    logic                  retire_bad;
    logic                  retire_ok;

    // FL_DEPTH is a power of two, so a plain add wraps the index and toggles the wrap bit.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return p + PTR_W'(1);
    endfunction

    assign alloc_valid = (tail_q != spec_head_q);
    assign alloc_tag   = mem_q[spec_head_q[IDX_W-1:0]];
    assign free_count  = tail_q - spec_head_q;
    assign err         = err_q;

    assign alloc_fire = alloc_req && alloc_valid && !flush;
    assign retire_bad = retire_valid &&
                        ((retire_old_tag == '0) || (com_head_q == spec_head_q));
    assign retire_ok  = retire_valid && !retire_bad;

    always_comb begin
        spec_head_d = spec_head_q;
        com_head_d  = com_head_q;
        tail_d      = tail_q;
        err_d       = err_q | retire_bad;

        if (retire_ok) begin
            com_head_d = ptr_inc(com_head_q);
            tail_d     = ptr_inc(tail_q);
        end

        // Flush rewinds to the committed head as it stands after this cycle's retire.
        if (flush) begin
            spec_head_d = com_head_d;
        end else if (alloc_fire) begin
            spec_head_d = ptr_inc(spec_head_q);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < FL_DEPTH; i++) begin
                mem_q[i] <= PREG_WIDTH'(NUM_AREG + i);
            end
            spec_head_q <= '0;
            com_head_q  <= '0;
            tail_q      <= {1'b1, {IDX_W{1'b0}}};
            err_q       <= 1'b0;
        end else begin
            spec_head_q <= spec_head_d;
            com_head_q  <= com_head_d;
            tail_q      <= tail_d;
            err_q       <= err_d;
            if (retire_ok) begin
                mem_q[tail_q[IDX_W-1:0]] <= retire_old_tag;
            end
        end
    end

endmodule

// File: tb/tb_preg_free_list.sv
// Self-checking bench for preg_free_list: directed vector table, hand-written
// corner sequences and randomized traffic against a queue-based model.
module tb_preg_free_list;

    localparam int DEPTH = 32;
    localparam int AREG  = 32;

    logic       clk = 1'b0;
    logic       rst;
    logic       alloc_req;
    logic       alloc_valid;
    logic [5:0] alloc_tag;
    logic       retire_valid;
    logic [5:0] retire_old_tag;
    logic       flush;
    logic [5:0] free_count;
    logic       err;

    preg_free_list #(
        .PREG_WIDTH (6),
        .NUM_PREG   (64),
        .NUM_AREG   (32),
        .FL_DEPTH   (32)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .alloc_req      (alloc_req),
        .alloc_valid    (alloc_valid),
        .alloc_tag      (alloc_tag),
        .retire_valid   (retire_valid),
        .retire_old_tag (retire_old_tag),
        .flush          (flush),
        .free_count     (free_count),
        .err            (err)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    // Model: freeq holds every tag between committed head and tail, oldest first;
    // the first nspec entries are handed out speculatively.
    int freeq[$];
    int nspec;
    bit merr;

    typedef struct {
        bit a;
        bit r;
        int t;
        bit f;
        int ev;
        int etag;
        int ecnt;
        int eerr;
    } vec_t;

    vec_t tbl[9];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        freeq.delete();
        for (int i = 0; i < DEPTH; i++) freeq.push_back(AREG + i);
        nspec = 0;
        merr  = 1'b0;
    endtask

    task automatic model_step(input bit a, input bit r, input int t, input bit f);
        bit fire;
        bit rok;
        fire = a && (nspec < DEPTH) && !f;
        rok  = r && (t != 0) && (nspec > 0);
        if (r && !rok) merr = 1'b1;
        if (rok) begin
            void'(freeq.pop_front());
            freeq.push_back(t);
            nspec--;
        end
        if (f) nspec = 0;
        else if (fire) nspec++;
    endtask

    task automatic model_check(input string tagname);
        check({tagname, ".valid"}, int'(alloc_valid), int'(nspec < DEPTH));
        check({tagname, ".count"}, int'(free_count), DEPTH - nspec);
        check({tagname, ".err"}, int'(err), int'(merr));
        if (nspec < DEPTH) check({tagname, ".tag"}, int'(alloc_tag), freeq[nspec]);
    endtask

    task automatic do_cycle(input bit a, input bit r, input int t, input bit f);
        alloc_req      = a;
        retire_valid   = r;
        retire_old_tag = 6'(t);
        flush          = f;
        @(posedge clk);
        model_step(a, r, t, f);
        #1;
        alloc_req      = 1'b0;
        retire_valid   = 1'b0;
        retire_old_tag = '0;
        flush          = 1'b0;
    endtask

    task automatic do_reset();
        rst            = 1'b0;
        alloc_req      = 1'b0;
        retire_valid   = 1'b0;
        retire_old_tag = '0;
        flush          = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, ".valid"}, int'(alloc_valid), 1);
        check({name, ".tag"}, int'(alloc_tag), 32);
        check({name, ".count"}, int'(free_count), 32);
        check({name, ".err"}, int'(err), 0);
    endtask

    initial begin
        bit a, r, f;
        int t;

        // Allocate 4, retire 7, flush, then combined alloc+retire+flush.
        tbl[0] = '{1, 0, 0, 0, 1, 33, 31, 0};
        tbl[1] = '{1, 0, 0, 0, 1, 34, 30, 0};
        tbl[2] = '{1, 0, 0, 0, 1, 35, 29, 0};
        tbl[3] = '{1, 0, 0, 0, 1, 36, 28, 0};
        tbl[4] = '{0, 1, 7, 0, 1, 36, 29, 0};
        tbl[5] = '{0, 0, 0, 1, 1, 33, 32, 0};
        tbl[6] = '{1, 0, 0, 0, 1, 34, 31, 0};
        tbl[7] = '{1, 1, 9, 1, 1, 34, 32, 0};
        tbl[8] = '{1, 0, 0, 0, 1, 35, 31, 0};

        do_reset();
        check_reset_outputs("reset");

        for (int i = 0; i < 9; i++) begin
            do_cycle(tbl[i].a, tbl[i].r, tbl[i].t, tbl[i].f);
            check($sformatf("vec%0d.valid", i), int'(alloc_valid), tbl[i].ev);
            check($sformatf("vec%0d.tag", i), int'(alloc_tag), tbl[i].etag);
            check($sformatf("vec%0d.count", i), int'(free_count), tbl[i].ecnt);
            check($sformatf("vec%0d.err", i), int'(err), tbl[i].eerr);
        end

        // Drain the whole list in order, then an ignored 33rd request.
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            check($sformatf("drain%0d.tag", i), int'(alloc_tag), 32 + i);
            do_cycle(1, 0, 0, 0);
        end
        check("empty.valid", int'(alloc_valid), 0);
        check("empty.count", int'(free_count), 0);
        do_cycle(1, 0, 0, 0);
        check("extra_req.valid", int'(alloc_valid), 0);
        check("extra_req.count", int'(free_count), 0);

        // Empty list: a tag returned this cycle is not granted until the next.
        alloc_req = 1'b1;
        #1;
        check("empty_bypass.valid_before", int'(alloc_valid), 0);
        do_cycle(1, 1, 5, 0);
        check("empty_bypass.valid", int'(alloc_valid), 1);
        check("empty_bypass.tag", int'(alloc_tag), 5);
        check("empty_bypass.count", int'(free_count), 1);

        // Retire of tag 0 is an error and leaves the list alone.
        do_cycle(0, 1, 0, 0);
        check("tag0.err", int'(err), 1);
        check("tag0.count", int'(free_count), 1);
        check("tag0.tag", int'(alloc_tag), 5);
        repeat (3) do_cycle(0, 0, 0, 0);
        check("tag0.err_held", int'(err), 1);

        // Retire with nothing outstanding is an error.
        do_reset();
        check("no_alloc.err_cleared", int'(err), 0);
        do_cycle(0, 1, 9, 0);
        check("no_alloc.err", int'(err), 1);
        check("no_alloc.count", int'(free_count), 32);
        check("no_alloc.tag", int'(alloc_tag), 32);
        do_cycle(1, 0, 0, 0);
        check("no_alloc.err_held", int'(err), 1);

        // Asynchronous reset between edges after 10 allocations.
        do_reset();
        repeat (10) do_cycle(1, 0, 0, 0);
        check("pre_async.tag", int'(alloc_tag), 42);
        alloc_req    = 1'b1;
        retire_valid = 1'b1;
        retire_old_tag = 6'd11;
        #2;
        rst = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        alloc_req      = 1'b0;
        retire_valid   = 1'b0;
        retire_old_tag = '0;
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        do_cycle(0, 0, 0, 0);
        check_reset_outputs("post_async");

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            a = ($urandom_range(0, 99) < 55);
            r = (nspec > 0) && ($urandom_range(0, 99) < 45);
            t = int'($urandom_range(1, 63));
            f = ($urandom_range(0, 99) < 3);
            do_cycle(a, r, t, f);
            model_check($sformatf("rand%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
